// File: rtl/tetris_pkg.sv
// tetris_pkg: shared piece codes, bag constants and the lowest-set-bit picker.
package tetris_pkg;
  typedef enum logic [2:0] {I = 3'd0, O, T, S, Z, J, L} piece_e;
  localparam int NUM_PIECES = 7;
  localparam logic [6:0] BAG_FULL = 7'h7F;
  function automatic logic [2:0] lowest_set(input logic [6:0] m);
    lowest_set = '0;
    for (int k = NUM_PIECES - 1; k >= 0; k--)
      if (m[k]) lowest_set = 3'(k);
  endfunction
endpackage

// File: rtl/tetromino_bag_generator_if.sv
// tetromino_bag_generator_if: head/preview valid-ready bundle between bag generator and spawn/display.
interface tetromino_bag_generator_if #(parameter int queue_depth_p = 3);
  localparam int CW = $clog2(queue_depth_p + 1);
  logic [2:0] piece_o;
  logic valid_o;
  logic ready_i;
  logic [queue_depth_p*3-1:0] preview_o;
  logic [CW-1:0] count_o;
  modport master(output piece_o, valid_o, preview_o, count_o, input ready_i);
  modport slave(input piece_o, valid_o, preview_o, count_o, output ready_i);
endinterface

// File: rtl/piece_preview_fifo.sv
// piece_preview_fifo: shift-register piece queue with every entry visible; empty slots hold 0.
module piece_preview_fifo #(
  parameter int depth_p = 3,
  localparam int CW = $clog2(depth_p + 1)
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic push_i,
  input  logic pop_i,
  input  logic [2:0] data_i,
  output logic [depth_p*3-1:0] entries_o,
  output logic [CW-1:0] count_o
);
  logic [2:0] r_q [depth_p];
  logic [2:0] w_shift [depth_p];
  logic [CW-1:0] r_cnt;
  logic w_pop;
  logic [CW-1:0] w_tail;
  assign w_pop = pop_i && r_cnt != '0;
  assign w_tail = r_cnt - CW'(w_pop);
  assign count_o = r_cnt;
  for (genvar i = 0; i < depth_p; i++) begin : g_slot
    if (i < depth_p - 1) begin : g_mid
      assign w_shift[i] = r_q[i+1];
    end else begin : g_last
      assign w_shift[i] = '0;
    end
    assign entries_o[3*i +: 3] = r_q[i];
  end
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      r_cnt <= '0;
      for (int k = 0; k < depth_p; k++) r_q[k] <= '0;
    end else begin
      r_cnt <= w_tail + CW'(push_i);
      for (int k = 0; k < depth_p; k++)
        r_q[k] <= (push_i && CW'(k) == w_tail) ? data_i : w_pop ? w_shift[k] : r_q[k];
    end
endmodule

// File: rtl/tetromino_bag_generator.sv
// tetromino_bag_generator: turns raw random words into a 7-bag piece stream feeding a preview queue.
module tetromino_bag_generator
  import tetris_pkg::*;
#(
  parameter int width_p = 32,
  parameter int queue_depth_p = 3,
  parameter int max_tries_p = 8
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic [width_p-1:0] random_i,
  tetromino_bag_generator_if.master bus
);
  localparam int CW = $clog2(queue_depth_p + 1);
  localparam int TW = $clog2(max_tries_p + 1);
  logic [6:0] r_mask;
  logic [TW-1:0] r_tries;
  logic [2:0] w_c, w_pick;
  logic [7:0] w_avail;
  logic [6:0] w_left;
  logic [CW-1:0] w_cnt;
  logic w_ok, w_fall, w_room, w_acc, w_pop;
  logic w_unused_random;
  assign w_unused_random = ^random_i;
  assign w_c = random_i[2:0];
  assign w_avail = {1'b0, r_mask};
  assign w_ok = w_avail[w_c];
  assign w_fall = !w_ok && r_tries == TW'(max_tries_p - 1);
  assign w_pop = bus.valid_o && bus.ready_i;
  assign w_room = w_cnt != CW'(queue_depth_p) || w_pop;
  assign w_acc = w_room && (w_ok || w_fall);
  assign w_pick = w_ok ? w_c : lowest_set(r_mask);
  assign w_left = r_mask & ~(7'd1 << w_pick);
  // The mask never reaches zero: an emptied bag refills on the same edge.
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      r_mask <= BAG_FULL;
      r_tries <= '0;
    end else if (w_room) begin
      r_tries <= w_acc ? '0 : r_tries + 1'b1;
      if (w_acc) r_mask <= w_left == '0 ? BAG_FULL : w_left;
    end
  piece_preview_fifo #(.depth_p(queue_depth_p)) u_fifo (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .push_i(w_acc),
    .pop_i(w_pop),
    .data_i(w_pick),
    .entries_o(bus.preview_o),
    .count_o(w_cnt)
  );
  assign bus.count_o = w_cnt;
  assign bus.valid_o = w_cnt != '0;
  assign bus.piece_o = bus.preview_o[2:0];
endmodule

// File: tb/tb_tetromino_bag_generator.sv
// tb_tetromino_bag_generator: random and directed stimulus scored against a bag-of-shapes reference model.
module tb_tetromino_bag_generator;
  localparam int D = 3;
  localparam int MAXT = 8;
  localparam int W = 32;
  logic clk = 0;
  logic reset_i = 0;
  logic [W-1:0] random_i = '0;
  tetromino_bag_generator_if #(.queue_depth_p(D)) bus();
  tetromino_bag_generator #(.width_p(W), .queue_depth_p(D), .max_tries_p(MAXT)) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .random_i(random_i),
    .bus(bus)
  );
  always #5 clk = ~clk;

  int errs = 0, checks = 0;
  int exp_q[$];
  int bag[$];
  int popped[$];
  int tries = 0;
  bit has_push = 0;
  int pend = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic void refill();
    bag = {0, 1, 2, 3, 4, 5, 6};
  endfunction

  // Reference: the bag is an ascending list of shapes still to be dealt.
  function automatic void predict(input int c, input bit rdy);
    int pos = -1;
    bit pop = exp_q.size() > 0 && rdy;
    if (exp_q.size() < D || pop) begin
      foreach (bag[j]) if (bag[j] == c) pos = j;
      if (pos < 0 && tries + 1 == MAXT) pos = 0;
      if (pos >= 0) begin
        pend = bag[pos];
        bag.delete(pos);
        has_push = 1;
        tries = 0;
        if (bag.size() == 0) refill();
      end else tries++;
    end
  endfunction

  task automatic drive(input int c, input bit rdy);
    if (has_push) exp_q.push_back(pend);
    has_push = 0;
    random_i = $urandom();
    random_i[2:0] = 3'(c);
    bus.ready_i = rdy;
    predict(c, rdy);
  endtask

  task automatic cyc(input int c, input bit rdy);
    @(posedge clk);
    #1;
    drive(c, rdy);
  endtask

  task automatic do_reset(input int c);
    @(posedge clk);
    #1;
    if (has_push) exp_q.push_back(pend);
    has_push = 0;
    reset_i = 0;
    #1;
    check("rst_valid", bus.valid_o, 0);
    check("rst_count", bus.count_o, 0);
    check("rst_piece", bus.piece_o, 0);
    check("rst_preview", bus.preview_o, 0);
    exp_q.delete();
    refill();
    tries = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1;
    drive(c, 0);
  endtask

  always @(negedge clk)
    if (reset_i) begin
      check("count", bus.count_o, exp_q.size());
      check("valid", bus.valid_o, exp_q.size() > 0);
      for (int k = 0; k < D; k++)
        check("preview", bus.preview_o[3*k +: 3], k < exp_q.size() ? exp_q[k] : 0);
      if (bus.valid_o && bus.ready_i && exp_q.size() > 0) begin
        check("piece", bus.piece_o, exp_q[0]);
        popped.push_back(int'(bus.piece_o));
        void'(exp_q.pop_front());
      end
    end

  initial begin
    bit [6:0] seen;
    refill();
    bus.ready_i = 0;
    do_reset(0);
    cyc(1, 0);
    cyc(2, 0);
    repeat (5) cyc($urandom_range(0, 7), 0);
    foreach (exp_q[j]) ;
    cyc(6, 1); cyc(5, 1); cyc(4, 1); cyc(3, 1);
    cyc(2, 1); cyc(1, 1); cyc(0, 1); cyc(3, 1);
    repeat (4) cyc($urandom_range(0, 7), 1);
    do_reset(7);
    repeat (20) cyc(7, 1);
    do_reset(2);
    cyc(2, 1); cyc(2, 1); cyc(4, 1);
    repeat (300) cyc($urandom_range(0, 7), $urandom_range(0, 3) != 0);
    repeat (200) cyc($urandom_range(0, 7), $urandom_range(0, 3) == 0);
    cyc(5, 0);
    cyc(5, 1);
    do_reset(3);
    cyc(5, 0);
    cyc(1, 0);
    do_reset($urandom_range(0, 7));
    popped.delete();
    for (int n = 0; n < 200 && popped.size() < 7; n++) cyc($urandom_range(0, 7), 1);
    check("deal_budget", popped.size() >= 7, 1);
    seen = '0;
    for (int n = 0; n < 7 && n < popped.size(); n++) seen[popped[n]] = 1'b1;
    check("bag_permutation", seen, 7'h7F);
    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/tetromino_bag_generator.md
# tetromino_bag_generator

Converts the raw per-cycle word from the LFSR union into a fair "7-bag" stream of tetromino codes: every run of 7 dealt pieces is a permutation of all seven shapes. It sits directly downstream of the random source and upstream of the spawn logic. It keeps a small preview queue with a valid/ready head, so the playfield can spawn and the display can show upcoming pieces.

## Interface
- `width_p`, 32: width of `random_i`; only bits [2:0] are used.
- `queue_depth_p`, 3: preview queue depth, >= 1.
- `max_tries_p`, 8: consecutive rejected draws before the fallback pick.
- `clk_i` input 1: single clock, rising edge.
- `reset_i` input 1: asynchronous, active-low (0 = reset).
- `random_i` input width_p: new random word every cycle.
- `piece_o` output 3: head piece code 0..6 (I,O,T,S,Z,J,L).
- `valid_o` output 1: head entry present.
- `ready_i` input 1: consumer takes the head when `valid_o && ready_i`.
- `preview_o` output queue_depth_p*3: entry k = k-th piece after head, k=0 is head; unfilled slots read 0.
- `count_o` output $clog2(queue_depth_p+1): number of queued entries.

## Operation
- Reset values:
  - bag mask = 7'h7F, all shapes available.
  - try counter = 0; queue empty.
  - `valid_o` = 0, `count_o` = 0, `piece_o` = 0, `preview_o` = 0.
- Draw stage runs in any cycle where push is permitted: `count < depth`, or `count == depth` with a pop in the same cycle.
- Candidate `c = random_i[2:0]`.
  - Accept if `c != 7` and `mask[c] == 1`.
  - Otherwise reject and increment the try counter.
- Fallback: when a reject would make the try counter reach `max_tries_p`, instead accept the lowest-index set bit of `mask` and clear the counter.
- On accept:
  - Push `c` to the queue tail and clear `mask[c]`.
  - Clear the try counter.
  - If the resulting mask is 0, the mask becomes 7'h7F on the same edge.
- In cycles where push is not permitted, the draw stage holds: mask and try counter are unchanged, and `random_i` is ignored.
- Pop: on `valid_o && ready_i`, the head is removed and later entries shift forward.
- Simultaneous push and pop:
  - When full: count is unchanged and the new piece lands at the last slot.
  - When count == 1: the new piece becomes the head next cycle.
- `ready_i` while `valid_o == 0` has no effect.
- Reset asserted mid-operation:
  - Immediately clears the queue, mask and try counter; any partial bag is discarded.
  - After release, dealing restarts with a fresh full bag.

## Timing
- Piece accepted at edge N is visible on `piece_o`/`preview_o` after edge N; latency from the `random_i` sample to visible output is 1 cycle.
- After reset release with always-acceptable randoms, `count_o` reads 1, 2, …, depth after edges 1..depth.
- Worst-case fill gap is `max_tries_p` cycles per piece.
- All outputs are registered, with no combinational path from `ready_i` or `random_i` to any output.
- `ready_i` only affects state at the edge.

## Structure
- `tetris_pkg` holds:
  - `piece_e` enum (3-bit: I=0, O=1, T=2, S=3, Z=4, J=5, L=6);
  - `NUM_PIECES` = 7;
  - `BAG_FULL` = 7'h7F.
- Sub-module `piece_preview_fifo`: shift-register queue parameterised by depth, with push/pop, full visibility of all entries, and count output.
- The top level contains the bag mask, try counter, accept/fallback logic and lowest-set-bit priority encoder.

## Test plan
- Reset, `ready_i=0`, `random_i[2:0]` = 0,1,2 → `count_o` = 1,2,3; `preview_o` = {0,1,2}; mask = 7'h78; draw stalls while full.
- Hold `ready_i=1`, drive 6,5,4,3,2,1,0,3 → pieces dealt in that order; bag refills after the 7th; the 8th (3) is accepted from the fresh bag.
- Drive 7 repeatedly from reset (`max_tries_p=8`) → first accept on the 8th cycle via fallback yields piece 0; the next fallback yields 1.
- Within one bag, deal 2, then drive 2,2,4 → the two 2s are rejected (try counter 1, 2); 4 is accepted and the counter clears.
- Full queue, `ready_i=1`, `random_i`=5 (available) in the same cycle → head pops, `count_o` stays 3, and 5 appears at `preview_o` slot 2.
- Assert `reset_i` low mid-bag with 2 entries queued → `valid_o`/`count_o` go 0 asynchronously; after release, 7 consecutive deals form a full permutation.
